// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard control (RAW scoreboard, FFT sync wait, branch flush)
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dec_*                           decode-stage instruction attributes
//   ex_branch_taken                 execute resolved a taken branch
//   ex_wr_en, ex_mem_rd, ex_wr_reg  execute-stage write (forwarding source)
//   wb_wr_en, wb_wr_reg             writeback retire
//   fft_done                        one FFT write completed (pulse)
//   stall_fd, stall_de              stall fetch/decode and decode/execute pipes
//   flush_fd, flush_de              flush fetch/decode and decode/execute pipes
//   fwd_a, fwd_b                    forward EX result to operand A/B
//   state                           FSM state (debug)
// Optional feature: define HAZARD_FORWARD_EN to forward EX ALU results
// instead of stalling on them.
module hazard_ctrl #(
    parameter int REGW         = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int FFTCNTW      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dec_valid,
    input  logic            dec_use_a,
    input  logic            dec_use_b,
    input  logic [REGW-1:0] dec_rs_a,
    input  logic [REGW-1:0] dec_rs_b,
    input  logic            dec_wr_en,
    input  logic [REGW-1:0] dec_wr_reg,
    input  logic            dec_fft_wr_en,
    input  logic            dec_syn,
    input  logic            ex_branch_taken,
    input  logic            ex_wr_en,
    input  logic            ex_mem_rd,
    input  logic [REGW-1:0] ex_wr_reg,
    input  logic            wb_wr_en,
    input  logic [REGW-1:0] wb_wr_reg,
    input  logic            fft_done,
    output logic            stall_fd,
    output logic            stall_de,
    output logic            flush_fd,
    output logic            flush_de,
    output logic            fwd_a,
    output logic            fwd_b,
    output logic [1:0]      state
);
    localparam int NREG = 1 << REGW;
    localparam logic [1:0] RUN = 2'd0, FLUSH = 2'd1, FFT_WAIT = 2'd2;
    localparam logic [FFTCNTW-1:0] FFT_MAX = '1;
    localparam logic [FFTCNTW-1:0] FFT_ONE = 1;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    logic [1:0]         st, st_nxt;
    logic [3:0]         fcnt, fcnt_nxt;
    logic [NREG-1:0]    pend, pend_nxt;
    logic [FFTCNTW-1:0] fft_cnt, fft_cnt_nxt;
    logic raw_a, raw_b, fwd_a_i, fwd_b_i, stall_i, flush_i, issue, fft_issue, fft_dec;
    always_comb begin
        // a retiring writeback clears the hazard in the same cycle
        raw_a = dec_valid & dec_use_a & pend[dec_rs_a] & !(wb_wr_en & wb_wr_reg == dec_rs_a);
        raw_b = dec_valid & dec_use_b & pend[dec_rs_b] & !(wb_wr_en & wb_wr_reg == dec_rs_b);
`ifdef HAZARD_FORWARD_EN
        // EX holds the youngest write to the register, so its ALU result is always current
        fwd_a_i = raw_a & ex_wr_en & !ex_mem_rd & ex_wr_reg == dec_rs_a;
        fwd_b_i = raw_b & ex_wr_en & !ex_mem_rd & ex_wr_reg == dec_rs_b;
`else
        fwd_a_i = 1'b0;
        fwd_b_i = 1'b0;
`endif
        flush_i = ex_branch_taken | st == FLUSH;
        stall_i = !flush_i & ((raw_a & !fwd_a_i) | (raw_b & !fwd_b_i)
                  | (dec_valid & dec_syn & fft_cnt != '0)
                  | (dec_valid & dec_fft_wr_en & fft_cnt == FFT_MAX)
                  | (st == FFT_WAIT & fft_cnt != '0));
        issue     = dec_valid & dec_wr_en & !stall_i & !flush_i;
        fft_issue = dec_valid & dec_fft_wr_en & !stall_i & !flush_i;
        fft_dec   = fft_done & fft_cnt != '0;
        // set after clear so a same-cycle set/clear of one register leaves it pending
        pend_nxt = pend;
        if (wb_wr_en) pend_nxt[wb_wr_reg] = 1'b0;
        if (issue) pend_nxt[dec_wr_reg] = 1'b1;
        fft_cnt_nxt = (fft_issue & !fft_dec & fft_cnt != FFT_MAX) ? fft_cnt + FFT_ONE :
                      (fft_dec & !fft_issue) ? fft_cnt - FFT_ONE : fft_cnt;
        st_nxt   = RUN;
        fcnt_nxt = fcnt;
        if (ex_branch_taken) begin
            st_nxt   = FLUSH;
            fcnt_nxt = FLUSH_LOAD;
        end else if (st == RUN) begin
            st_nxt = (dec_valid & dec_syn & fft_cnt != '0) ? FFT_WAIT : RUN;
        end else if (st == FLUSH) begin
            st_nxt   = fcnt == 4'd0 ? RUN : FLUSH;
            fcnt_nxt = fcnt == 4'd0 ? fcnt : fcnt - 4'd1;
        end else if (st == FFT_WAIT) begin
            st_nxt = fft_cnt == '0 ? RUN : FFT_WAIT;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= RUN;
            fcnt    <= '0;
            pend    <= '0;
            fft_cnt <= '0;
        end else begin
            st      <= st_nxt;
            fcnt    <= fcnt_nxt;
            pend    <= pend_nxt;
            fft_cnt <= fft_cnt_nxt;
        end
    end
`ifndef HAZARD_FORWARD_EN
    logic unused_ex;
    assign unused_ex = ^{ex_wr_en, ex_mem_rd, ex_wr_reg};
`endif
    // outputs are forced low while reset is held
    assign stall_fd = stall_i & rst_n;
    assign stall_de = stall_i & rst_n;
    assign flush_fd = flush_i & rst_n;
    assign flush_de = flush_i & rst_n;
    assign fwd_a    = fwd_a_i & !flush_i & rst_n;
    assign fwd_b    = fwd_b_i & !flush_i & rst_n;
    assign state    = st;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk = 1'b0, rst_n;
    logic dec_valid, dec_use_a, dec_use_b, dec_wr_en, dec_fft_wr_en, dec_syn;
    logic [2:0] dec_rs_a, dec_rs_b, dec_wr_reg, ex_wr_reg, wb_wr_reg;
    logic ex_branch_taken, ex_wr_en, ex_mem_rd, wb_wr_en, fft_done;
    logic stall_fd, stall_de, flush_fd, flush_de, fwd_a, fwd_b;
    logic [1:0] state;
    int vecs = 0, errs = 0;
    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
        .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b), .dec_wr_en(dec_wr_en),
        .dec_wr_reg(dec_wr_reg), .dec_fft_wr_en(dec_fft_wr_en), .dec_syn(dec_syn),
        .ex_branch_taken(ex_branch_taken), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
        .ex_wr_reg(ex_wr_reg), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
        .fft_done(fft_done), .stall_fd(stall_fd), .stall_de(stall_de),
        .flush_fd(flush_fd), .flush_de(flush_de), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .state(state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        dec_valid = 0; dec_use_a = 0; dec_use_b = 0; dec_wr_en = 0; dec_fft_wr_en = 0;
        dec_syn = 0; dec_rs_a = 0; dec_rs_b = 0; dec_wr_reg = 0; ex_branch_taken = 0;
        ex_wr_en = 0; ex_mem_rd = 0; ex_wr_reg = 0; wb_wr_en = 0; wb_wr_reg = 0; fft_done = 0;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        clr();
        rst_n = 0; ex_branch_taken = 1; dec_valid = 1; dec_syn = 1;
        #3;
        chk("rst_flush", flush_de, 0);
        chk("rst_stall", stall_de, 0);
        chk("rst_state", state, 0);
        cyc(); cyc(); clr(); rst_n = 1; cyc();
        dec_valid = 1; dec_wr_en = 1; dec_wr_reg = 3;
        #1 chk("issue_r3", stall_de, 0);
        cyc();
        dec_wr_en = 0; dec_use_a = 1; dec_rs_a = 3;
        for (int i = 0; i < 3; i++) begin
            #1 chk("raw_r3_stall", stall_de, 1);
            chk("raw_r3_stall_fd", stall_fd, 1);
            cyc();
        end
        wb_wr_en = 1; wb_wr_reg = 3;
        #1 chk("raw_r3_wb", stall_de, 0);
        cyc();
        wb_wr_en = 0;
        #1 chk("raw_r3_clear", stall_de, 0);
        cyc(); clr();
        dec_valid = 1; dec_wr_en = 1; dec_wr_reg = 2; cyc();
        wb_wr_en = 1; wb_wr_reg = 2;
        #1 chk("setclr_issue", stall_de, 0);
        cyc(); clr();
        dec_valid = 1; dec_use_b = 1; dec_rs_b = 2;
        #1 chk("setclr_keep", stall_de, 1);
        dec_use_b = 0;
        #1 chk("unused_src", stall_de, 0);
        clr(); wb_wr_en = 1; wb_wr_reg = 2; cyc(); clr();
        ex_branch_taken = 1; dec_valid = 1; dec_wr_en = 1; dec_wr_reg = 4;
        #1 chk("br_flush_de", flush_de, 1);
        chk("br_flush_fd", flush_fd, 1);
        chk("br_stall", stall_de, 0);
        cyc(); clr();
        #1 chk("flush1", flush_de, 1);
        chk("flush1_state", state, 1);
        cyc();
        #1 chk("flush2", flush_de, 1);
        chk("flush2_state", state, 1);
        cyc();
        #1 chk("flush_end", flush_de, 0);
        chk("flush_end_state", state, 0);
        dec_valid = 1; dec_use_a = 1; dec_rs_a = 4;
        #1 chk("flushed_no_sb", stall_de, 0);
        cyc(); clr();
        fft_done = 1; cyc(); clr();
        dec_valid = 1; dec_fft_wr_en = 1; cyc(); cyc(); clr();
        #1 chk("fft_cnt2", dut.fft_cnt, 2);
        dec_valid = 1; dec_syn = 1;
        #1 chk("syn_stall", stall_de, 1);
        chk("syn_state", state, 0);
        cyc();
        #1 chk("wait_state", state, 2);
        chk("wait_stall", stall_de, 1);
        fft_done = 1; cyc(); fft_done = 0;
        #1 chk("wait_cnt1", stall_de, 1);
        cyc(); fft_done = 1; cyc(); fft_done = 0;
        #1 chk("wait_done", stall_de, 0);
        chk("wait_done_state", state, 2);
        cyc();
        #1 chk("wait_exit", state, 0);
        cyc(); clr();
        dec_valid = 1; dec_fft_wr_en = 1; repeat (3) cyc(); clr();
        dec_valid = 1; dec_syn = 1; cyc(); clr();
        #1 chk("wait3_state", state, 2);
        ex_branch_taken = 1;
        #1 chk("wait_br_flush", flush_de, 1);
        chk("wait_br_stall", stall_de, 0);
        cyc(); clr();
        #1 chk("wait_br_state", state, 1);
        chk("wait_br_cnt", dut.fft_cnt, 3);
        cyc(); cyc();
        #1 chk("wait_br_run", state, 0);
        dec_valid = 1; dec_syn = 1; cyc(); clr();
        #1 chk("rewait_stall", stall_de, 1);
        chk("rewait_state", state, 2);
        rst_n = 0;
        #1 chk("async_rst_state", state, 0);
        chk("async_rst_stall", stall_de, 0);
        cyc(); rst_n = 1; cyc();
        #1 chk("post_rst_state", state, 0);
        chk("post_rst_stall", stall_de, 0);
        chk("post_rst_cnt", dut.fft_cnt, 0);
        dec_valid = 1; dec_fft_wr_en = 1; repeat (15) cyc();
        #1 chk("fft_sat_cnt", dut.fft_cnt, 15);
        chk("fft_sat_stall", stall_de, 1);
        clr();
        #1 chk("fft_sat_idle", stall_de, 0);
        dec_valid = 1; dec_wr_en = 1; dec_wr_reg = 5; cyc(); clr();
        dec_valid = 1; dec_use_a = 1; dec_rs_a = 5; ex_wr_en = 1; ex_wr_reg = 5;
`ifdef HAZARD_FORWARD_EN
        #1 chk("fwd_a", fwd_a, 1);
        chk("fwd_stall", stall_de, 0);
        ex_mem_rd = 1;
        #1 chk("load_no_fwd", fwd_a, 0);
        chk("load_stall", stall_de, 1);
`else
        #1 chk("fwd_a_off", fwd_a, 0);
        chk("nofwd_stall", stall_de, 1);
`endif
        chk("fwd_b_idle", fwd_b, 0);
        clr();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
